// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART definitions (scheduler FSM encoding, register map)
// Rev 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [31:0] C_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] C_CON_ADDR = 32'h4000_0020;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// uart_byte_fifo : 8-bit wide synchronous FIFO with push/pop/flush
// Rev 1.0
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    import uart_pkg::*;

    localparam int              C_AW   = $clog2(DEPTH);
    localparam int              C_CW   = C_AW + 1;
    localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_CW-1:0] r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign full      = (r_count == C_FULL);
    assign empty     = (r_count == '0);
    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge sysclk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : round-robin sharing of one UART sender by two byte FIFOs
// Rev 1.0
// ============================================================================
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       flush,
    input  logic       tx_status,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       timeout_err
);
    import uart_pkg::*;

    localparam logic [7:0] C_TIMEOUT = 8'(BUSY_TIMEOUT);

    logic       w_full0;
    logic       w_empty0;
    logic       w_full1;
    logic       w_empty1;
    logic [7:0] w_head0;
    logic [7:0] w_head1;
    logic       w_launch;
    logic       w_pick;
    logic       w_pop0;
    logic       w_pop1;

    state_t     r_state;
    logic       r_last_grant;
    logic       r_grant_id;
    logic [7:0] r_timer;

    assign req0_ready = !w_full0;
    assign req1_ready = !w_full1;

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (req0_valid),
        .push_data (req0_data),
        .pop       (w_pop0),
        .flush     (flush),
        .pop_data  (w_head0),
        .full      (w_full0),
        .empty     (w_empty0)
    );

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (req1_valid),
        .push_data (req1_data),
        .pop       (w_pop1),
        .flush     (flush),
        .pop_data  (w_head1),
        .full      (w_full1),
        .empty     (w_empty1)
    );

    // With both queues occupied, the requester that did not go last wins.
    always_comb begin
        w_pick = 1'b0;
        if (!w_empty0 && !w_empty1) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = w_empty0;
        end
    end

    assign w_launch = (r_state == IDLE) && tx_status && !(w_empty0 && w_empty1);
    assign w_pop0   = w_launch && !w_pick;
    assign w_pop1   = w_launch && w_pick;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_timer      <= '0;
            tx_en        <= 1'b0;
            tx_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_id      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            tx_en       <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        tx_data      <= w_pick ? w_head1 : w_head0;
                        r_grant_id   <= w_pick;
                        r_last_grant <= w_pick;
                        busy         <= 1'b1;
                        r_state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_en   <= 1'b1;
                    r_timer <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_status) begin
                        r_state <= WAIT_DONE;
                    end else if (r_timer + 8'd1 == C_TIMEOUT) begin
                        // Sender never acknowledged: drop the byte silently.
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_status) begin
                        done    <= 1'b1;
                        done_id <= r_grant_id;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between two byte sources:
- requester 0: the CPU, via the memory-mapped TXD write path.
- requester 1: a hardware source, such as RX echo or a status reporter.

Each requester has its own small FIFO. A round-robin arbiter picks the next byte, and an FSM drives the sender's one-cycle enable and then tracks its busy/idle status until the byte completes. The block sits between the peripheral register file and UART_Sender, in the sysclk domain.

Parameters:
FIFO_DEPTH, 4, entries per requester FIFO; must be a power of 2 and at least 2
BUSY_TIMEOUT, 16, max cycles allowed for tx_status to fall after tx_en; 8-bit counter, range 1..255

Ports:
sysclk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 offers a byte
req0_data  input  8  requester 0 byte
req0_ready  output  1  requester 0 FIFO not full
req1_valid  input  1  requester 1 offers a byte
req1_data  input  8  requester 1 byte
req1_ready  output  1  requester 1 FIFO not full
flush  input  1  synchronous: drop all queued bytes
tx_status  input  1  sender idle (1) / busy (0)
tx_en  output  1  one-cycle launch pulse to sender
tx_data  output  8  byte to sender, held stable from LAUNCH until return to IDLE
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse: byte finished
done_id  output  1  requester whose byte finished; valid with done
timeout_err  output  1  one-cycle pulse: sender never went busy

Behaviour:
- Reset is asynchronous, active-low. All of the following are 0 at reset:
  - FIFOs empty, state IDLE, tx_en, tx_data, busy, done, done_id, timeout_err.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Push handshake:
  - A byte is accepted on a rising edge where reqN_valid && reqN_ready.
  - reqN_ready = FIFO N not full; it is combinational from the FIFO count.
  - Push and pop of the same FIFO in one cycle are both allowed.
  - When a FIFO is full, a push is refused even if a pop happens in the same cycle.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Leaves only when tx_status==1 and at least one FIFO is non-empty.
  - If exactly one FIFO is non-empty, that requester is granted.
  - If both are non-empty, the requester != last_grant is granted.
  - On the grant edge: pop the head into tx_data, set grant_id, update last_grant, go to LAUNCH.
- LAUNCH:
  - tx_en=1 for exactly this one cycle.
  - Clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_status==0 -> WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, pulse timeout_err for 1 cycle and go to IDLE.
  - On timeout the byte is dropped; no done pulse.
- WAIT_DONE:
  - tx_status==1 -> pulse done=1 for 1 cycle with done_id=grant_id, then go to IDLE.
  - There is no timeout in this state; sender frame length is bounded by the baud generator.
- Latency:
  - Byte accepted at edge k with empty FIFOs, FSM idle and tx_status=1 -> FIFO non-empty after k.
  - Grant at edge k+1; tx_en high in the cycle after edge k+2.
- Back-to-back: after done, IDLE may grant again on the next edge. The minimum gap between tx_en pulses is sender frame time + 3 cycles.
- flush:
  - Empties both FIFOs on the edge where it is sampled high.
  - A byte already in LAUNCH, WAIT_BUSY or WAIT_DONE completes normally.
  - Pushes in the flush cycle are discarded.
- busy=1 in every state except IDLE.
- tx_data is not modified outside the grant edge.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is one bit wider, so full and empty are distinguished.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
  - the TXD/CON register address constants 32'h40000018 and 32'h40000020, for reuse by the register file.
- One sub-module, uart_byte_fifo:
  - Parameterised on depth, 8-bit wide, synchronous push/pop/flush, full/empty outputs.
  - Instantiated twice.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single byte: req0 pushes 8'hA5, tx_status=1, sender model goes busy 2 cycles after tx_en and stays busy 20 cycles -> expected:
  - one tx_en pulse with tx_data=8'hA5, 2 cycles after the push edge.
  - done=1, done_id=0 one cycle after tx_status returns high.
- Round-robin: req0 pushes 8'h01,8'h02 and req1 pushes 8'h11,8'h12, all in one burst -> sender sees 01,11,02,12 in that order; done_id sequence is 0,1,0,1.
- FIFO full: sender held busy (tx_status=0); req1 pushes 5 bytes with FIFO_DEPTH=4 -> req1_ready drops after the 4th accept, the 5th byte is not accepted, and the 4 accepted bytes are later sent in order.
- Timeout: tx_status stuck at 1 after tx_en -> timeout_err pulses exactly 16 cycles after LAUNCH; no done pulse; the next queued byte launches afterwards.
- Flush mid-transfer: 3 bytes queued, first byte in WAIT_DONE, flush pulsed -> first byte completes with done; the other two are never sent; busy=0 after done.
- Async reset mid-transfer: reset low during WAIT_BUSY -> immediately tx_en=0, busy=0, ready=1 on both ports, and queued bytes are gone after release.
